// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native picorv32-style memory bus.
// Latency: grant registered, 1 cycle after valid; ready/rdata pass through combinationally.
// Backpressure: the non-granted master sees ready=0 until it wins; one IDLE turnaround follows each transfer.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   m0_mem_* / m1_mem_*   master request (valid/instr/addr/wdata/wstrb) and response (ready/rdata)
//   s_mem_*               downstream request mirror and slave response
//   grant                 one-hot owner (bit0 = m0, bit1 = m1), 0 when idle
//   timeout_err           sticky watchdog flag
//
// Optional feature macro: ARB_TIMEOUT_EN enables the wait-state watchdog
// (TIMEOUT cycles, ERR_RDATA returned). Without it, transfers wait forever
// and timeout_err is tied to 0.

module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,

  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,

  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  // The watchdog counter is 8 bits wide, so only 1..255 is meaningful.
  if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_bus_arbiter: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t     state_q;
  logic       last_q;     // 0: m0 was granted last, 1: m1 was granted last
  logic [1:0] grant_q;
  logic       own0;
  logic       own1;
  logic       sel_valid;  // owner's valid, 0 when idle
  logic       timeout_hit;

  assign own0      = (state_q == GNT0);
  assign own1      = (state_q == GNT1);
  assign sel_valid = (own0 & m0_mem_valid) | (own1 & m1_mem_valid);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [7:0] cnt_q;
  logic       err_q;

  // A real response in the limit cycle takes priority over the watchdog.
  assign timeout_hit = sel_valid & ~s_mem_ready & (cnt_q == TIMEOUT_CNT);
  assign timeout_err = err_q;

  // Held at zero while idle so every grant starts counting from 0;
  // saturates at 8'hFF rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        cnt_q <= 8'd0;
      end else if (!s_mem_ready && cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Downstream request mirrors the owner; all zero while idle.
  assign s_mem_valid = sel_valid & ~timeout_hit;
  assign s_mem_instr = (own0 & m0_mem_instr) | (own1 & m1_mem_instr);
  assign s_mem_addr  = own0 ? m0_mem_addr  : (own1 ? m1_mem_addr  : 32'd0);
  assign s_mem_wdata = own0 ? m0_mem_wdata : (own1 ? m1_mem_wdata : 32'd0);
  assign s_mem_wstrb = own0 ? m0_mem_wstrb : (own1 ? m1_mem_wstrb : 4'd0);

  // Ready is qualified with the owner's valid so a master that abandons its
  // request never sees a completion.
  assign m0_mem_ready = own0 & m0_mem_valid & (s_mem_ready | timeout_hit);
  assign m1_mem_ready = own1 & m1_mem_valid & (s_mem_ready | timeout_hit);
  assign m0_mem_rdata = !own0 ? 32'd0 : (timeout_hit ? ERR_RDATA : s_mem_rdata);
  assign m1_mem_rdata = !own1 ? 32'd0 : (timeout_hit ? ERR_RDATA : s_mem_rdata);

  assign grant = grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;      // m0 wins the first tie
      grant_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_mem_valid && (!m1_mem_valid || last_q)) begin
            state_q <= GNT0;
            grant_q <= 2'b01;
            last_q  <= 1'b0;
          end else if (m1_mem_valid) begin
            state_q <= GNT1;
            grant_q <= 2'b10;
            last_q  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          // Completion, abandoned request or watchdog all release the bus.
          if (!sel_valid || s_mem_ready || timeout_hit) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter for the native picorv32-style memory bus (valid/ready, addr/wstrb/wdata/rdata, instr). It sits between the CPU and the bus-interface/peripheral decode, alongside a second master such as a DMA or bus test generator. It shares the single downstream bus between both masters using registered round-robin grants. An optional watchdog terminates transactions that no slave acknowledges.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles a granted transaction may wait for `s_mem_ready` before forced termination. Range 1..255.
- `ERR_RDATA`, default 32'hDEADBEEF: read data returned on a timed-out transaction.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m0_mem_valid`, `m0_mem_instr`  in  1 each  master 0 (CPU) request and instruction-fetch flag.
- `m0_mem_addr`, `m0_mem_wdata`  in  32 each  master 0 address and write data.
- `m0_mem_wstrb`  in  4  master 0 byte strobes; 0 means read.
- `m0_mem_ready`  out  1  master 0 completion.
- `m0_mem_rdata`  out  32  master 0 read data.
- `m1_*`  same set, same directions and widths  master 1.
- `s_mem_valid`, `s_mem_instr`  out  1 each  downstream request.
- `s_mem_addr`, `s_mem_wdata`  out  32 each  downstream address and write data.
- `s_mem_wstrb`  out  4  downstream byte strobes.
- `s_mem_ready`  in  1  downstream completion.
- `s_mem_rdata`  in  32  downstream read data.
- `grant`  out  2  one-hot current owner: bit 0 = m0, bit 1 = m1; 0 when idle.
- `timeout_err`  out  1  sticky flag: a transaction timed out.

## Operation
- The FSM has three states: IDLE, GNT0 and GNT1. `grant` decodes the state.
- In IDLE:
  - Only one master valid: grant that master.
  - Both valid: grant the master that was not last granted.
  - Neither valid: stay in IDLE.
  - `last` is updated on each grant.
- In GNTx:
  - `s_mem_*` mirrors master x combinationally.
  - `s_mem_valid` = `mx_mem_valid`.
  - `mx_mem_ready` = `s_mem_ready`.
  - `mx_mem_rdata` = `s_mem_rdata`.
- Non-granted master: `ready` = 0 and `rdata` = 0 at all times.
- In IDLE, all `s_mem_*` outputs are 0.
- In GNTx:
  - `s_mem_ready` = 1 completes the transfer; next state is IDLE.
  - Master x drops valid before ready (protocol violation): next state is IDLE, no ready is issued, and `timeout_err` is not affected.
- Arbitration is non-preemptive. A granted transaction is never interrupted except by timeout or reset.
- Reset values:
  - State IDLE, `last` = m1 (so m0 wins the first tie), wait counter 0, `timeout_err` 0.
  - Every output is 0.
- Reset mid-transaction: state returns to IDLE on that edge. No ready is issued for the aborted request.

## Timing
- Arbitration latency is 1 cycle. Master valid sampled at edge N gives `s_mem_valid` high in cycle N+1.
- Ready passes combinationally. `s_mem_ready` in cycle k gives `mx_mem_ready` in cycle k, pulsed for exactly 1 cycle.
- There is 1 mandatory IDLE turnaround cycle after each completion. Back-to-back requests from both masters therefore alternate with a 2-cycle minimum per transfer for a zero-wait slave.
- Wait counter:
  - 8 bits, cleared on entering GNTx.
  - Increments each GNTx cycle with `s_mem_ready` = 0.
  - Saturates and never wraps.

## Configuration
Macro `ARB_TIMEOUT_EN`.
- Defined, when the counter equals `TIMEOUT` in GNTx with `s_mem_ready` = 0:
  - In that cycle: `s_mem_valid` is forced to 0, `mx_mem_ready` = 1 and `mx_mem_rdata` = `ERR_RDATA`.
  - `timeout_err` is set (cleared only by `reset`).
  - Next state is IDLE.
- Defined, if `s_mem_ready` = 1 in the timeout cycle: the real response wins and no error is raised.
- Not defined: there is no counter; a transaction waits indefinitely and `timeout_err` is tied to 0.

## Test plan
- Single m0 read, slave ready 1 cycle after valid with rdata 32'h12345678:
  - `grant` = 01 one cycle after `m0_mem_valid`.
  - `m0_mem_rdata` = 32'h12345678 with `m0_mem_ready` for 1 cycle.
  - m1 sees ready 0.
- m0 and m1 both assert continuously, zero-wait slave:
  - `grant` sequence after reset is 01, 00, 10, 00, 01, 00, 10.
  - Each master completes every 4 cycles.
- m1 write (addr 32'hffff0060, wstrb 4'b0001, wdata 5) while m0 idle:
  - `s_mem_addr`, `s_mem_wstrb` and `s_mem_wdata` equal these values while `s_mem_valid`.
  - `grant` returns to 00 one cycle after ready.
- `ARB_TIMEOUT_EN`, `TIMEOUT` = 8, slave never ready:
  - `m0_mem_ready` with rdata 32'hDEADBEEF exactly 8 cycles after `s_mem_valid` rises.
  - `timeout_err` = 1 and stays 1.
- `reset` pulsed during m1's wait state:
  - Next cycle: `grant` = 00, `s_mem_valid` = 0, `m1_mem_ready` never asserted.
  - After reset, a tie grants m0 first.
- Slave ready in the same cycle the counter hits `TIMEOUT`: real rdata is returned and `timeout_err` stays 0.
